// File: rtl/tx_block_unpacker.sv
// TX FIFO read-side unpacker: splits each LANES*BSIZE word into one block per cycle,
// inserting 10GBASE-R idle blocks (or bubbles) when the FIFO runs dry.
module tx_block_unpacker #(
   parameter int LANES       = 4,
   parameter int BSIZE       = 66,
   parameter int DSIZE       = 264,
   parameter int INSERT_IDLE = 1,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [DSIZE-1:0] rdata,
   input  logic             rempty,
   output logic             rinc,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [BSIZE-1:0] out_block,
   output logic             out_idle,
   output logic [CNT_W-1:0] underrun_cnt
);

   localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);
   localparam logic [BSIZE-1:0] IDLE_BLK = {{(BSIZE - 10){1'b0}}, 8'h1E, 2'b10};

   logic [DSIZE-1:0] hold_q;
   logic [BSIZE-1:0] hold_lane [LANES];
   logic [IDX_W-1:0] idx;
   logic             held;
   logic             run;
   logic             advance;
   logic [CNT_W-1:0] cnt_q;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      assign hold_lane[g] = hold_q[g*BSIZE +: BSIZE];
   end

   // run keeps rinc low during the first cycle after reset release
   assign advance      = run & (out_ready | ~out_valid);
   assign rinc         = advance & ~held & ~rempty;
   assign underrun_cnt = cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run       <= 1'b0;
         held      <= 1'b0;
         idx       <= '0;
         out_valid <= 1'b0;
         out_block <= '0;
         out_idle  <= 1'b0;
         cnt_q     <= '0;
      end else begin
         run <= 1'b1;
         if (advance) begin
            if (held) begin
               out_block <= hold_lane[idx];
               out_valid <= 1'b1;
               out_idle  <= 1'b0;
               if (idx == LAST_IDX) begin
                  held <= 1'b0;
                  idx  <= '0;
               end else begin
                  idx <= idx + IDX_W'(1);
               end
            end else if (!rempty) begin
               out_block <= rdata[BSIZE-1:0];
               out_valid <= 1'b1;
               out_idle  <= 1'b0;
               held      <= 1'b1;
               idx       <= IDX_W'(1);
            end else begin
               cnt_q <= sat_inc(cnt_q);
               if (INSERT_IDLE != 0) begin
                  out_block <= IDLE_BLK;
                  out_valid <= 1'b1;
                  out_idle  <= 1'b1;
               end else begin
                  out_valid <= 1'b0;
                  out_idle  <= 1'b0;
               end
            end
         end
      end
   end

   // Word buffer is pure data: captured on every pop, never reset
   always_ff @(posedge clk) begin
      if (rinc) hold_q <= rdata;
   end

endmodule

// File: tb/tb_tx_block_unpacker.sv
// Directed bench for tx_block_unpacker: idle insertion, back-to-back words, stalls,
// counter saturation, async reset mid-word, and the INSERT_IDLE=0 variant.
module tb_tx_block_unpacker;

   logic          clk;
   logic          rst_n;
   logic [263:0]  rdata;
   logic          rempty;
   logic          rinc;
   logic          out_ready;
   logic          out_valid;
   logic [65:0]   out_block;
   logic          out_idle;
   logic [15:0]   underrun_cnt;

   logic          rst2_n;
   logic [263:0]  rdata2;
   logic          rempty2;
   logic          rinc2;
   logic          ready2;
   logic          valid2;
   logic [65:0]   block2;
   logic          idle2;
   logic [2:0]    cnt2;

   logic [263:0]  fifo [$];
   int            n_cmp = 0;
   int            n_err = 0;

   localparam logic [65:0] IDLE = 66'h0000_0000_0000_0007A;

   tx_block_unpacker #(.LANES(4), .BSIZE(66), .DSIZE(264), .INSERT_IDLE(1), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .rdata(rdata), .rempty(rempty), .rinc(rinc),
      .out_ready(out_ready), .out_valid(out_valid), .out_block(out_block),
      .out_idle(out_idle), .underrun_cnt(underrun_cnt)
   );

   tx_block_unpacker #(.LANES(4), .BSIZE(66), .DSIZE(264), .INSERT_IDLE(0), .CNT_W(3)) dut2 (
      .clk(clk), .rst_n(rst2_n), .rdata(rdata2), .rempty(rempty2), .rinc(rinc2),
      .out_ready(ready2), .out_valid(valid2), .out_block(block2),
      .out_idle(idle2), .underrun_cnt(cnt2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // FIFO model: show-ahead, consumed on the edge where rinc is high
   always @(posedge clk) begin
      if (rinc && fifo.size() > 0) void'(fifo.pop_front());
   end

   function automatic logic [65:0] lane(input int n, input int k);
      return {2'b11, 48'hA5A5_0000_0000, 8'(n), 8'(k)};
   endfunction

   function automatic logic [263:0] word(input int n);
      logic [263:0] w;
      for (int k = 0; k < 4; k++) w[66*k +: 66] = lane(n, k);
      return w;
   endfunction

   task automatic drive();
      rempty = (fifo.size() == 0);
      rdata  = rempty ? '0 : fifo[0];
   endtask

   task automatic cyc();
      @(negedge clk);
      drive();
      #1;
   endtask

   task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [65:0] blk, input logic v, input logic idl);
      chk({tag, ".block"}, out_block, blk);
      chk({tag, ".valid"}, 66'(out_valid), 66'(v));
      chk({tag, ".idle"}, 66'(out_idle), 66'(idl));
   endtask

   initial begin
      rst_n = 1'b0; out_ready = 1'b1;
      rst2_n = 1'b0; ready2 = 1'b1; rempty2 = 1'b1; rdata2 = '0;
      drive();

      // reset state
      repeat (3) @(negedge clk);
      #1;
      chk_out("reset", 66'd0, 1'b0, 1'b0);
      chk("reset.cnt", 66'(underrun_cnt), 66'd0);
      chk("reset.rinc", 66'(rinc), 66'd0);

      @(negedge clk);
      rst_n = 1'b1;
      drive();
      #1;
      chk("rel0.rinc", 66'(rinc), 66'd0);
      cyc();
      chk("rel1.valid", 66'(out_valid), 66'd0);
      for (int i = 1; i <= 5; i++) begin
         cyc();
         chk_out("idle", IDLE, 1'b1, 1'b1);
         chk("idle.cnt", 66'(underrun_cnt), 66'(i));
      end

      // back-to-back words W0, W1
      fifo.push_back(word(0));
      fifo.push_back(word(1));
      drive();
      #1;
      chk("b2b.rinc0", 66'(rinc), 66'd1);
      for (int j = 0; j < 8; j++) begin
         cyc();
         chk_out("b2b", lane(j / 4, j % 4), 1'b1, 1'b0);
         chk("b2b.rinc", 66'(rinc), 66'(j == 3));
      end
      chk("b2b.cnt", 66'(underrun_cnt), 66'd5);
      cyc();
      chk_out("resume", IDLE, 1'b1, 1'b1);
      chk("resume.cnt", 66'(underrun_cnt), 66'd6);

      // stall on lane 1 of W2
      fifo.push_back(word(2));
      drive();
      #1;
      chk("st.rinc0", 66'(rinc), 66'd1);
      cyc();
      chk_out("st.l0", lane(2, 0), 1'b1, 1'b0);
      cyc();
      chk_out("st.l1", lane(2, 1), 1'b1, 1'b0);
      out_ready = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk_out("st.hold", lane(2, 1), 1'b1, 1'b0);
         chk("st.rinc", 66'(rinc), 66'd0);
      end
      out_ready = 1'b1;
      cyc();
      chk_out("st.l2", lane(2, 2), 1'b1, 1'b0);
      cyc();
      chk_out("st.l3", lane(2, 3), 1'b1, 1'b0);

      // stall on lane 3 with the next word waiting: pop must wait
      fifo.push_back(word(3));
      out_ready = 1'b0;
      drive();
      #1;
      chk("st3.rinc", 66'(rinc), 66'd0);
      cyc();
      chk_out("st3.hold", lane(2, 3), 1'b1, 1'b0);
      chk("st3.rinc2", 66'(rinc), 66'd0);
      out_ready = 1'b1;
      #1;
      chk("st3.rinc3", 66'(rinc), 66'd1);
      for (int k = 0; k < 4; k++) begin
         cyc();
         chk_out("w3", lane(3, k), 1'b1, 1'b0);
      end
      cyc();
      chk_out("w3.idle", IDLE, 1'b1, 1'b1);
      chk("w3.cnt", 66'(underrun_cnt), 66'd7);

      // counter saturation
      force dut.cnt_q = 16'hFFFE;
      release dut.cnt_q;
      #1;
      chk("sat.pre", 66'(underrun_cnt), 66'h0FFFE);
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("sat", 66'(underrun_cnt), 66'h0FFFF);
      end

      // async reset while W4 lane 2 is presented
      fifo.push_back(word(4));
      drive();
      #1;
      chk("rst.rinc0", 66'(rinc), 66'd1);
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk_out("rst.pre", lane(4, k), 1'b1, 1'b0);
      end
      fifo.push_back(word(5));
      drive();
      #3;
      rst_n = 1'b0;
      #1;
      chk_out("rst.async", 66'd0, 1'b0, 1'b0);
      chk("rst.cnt", 66'(underrun_cnt), 66'd0);
      repeat (2) begin
         cyc();
         chk("rst.rinc", 66'(rinc), 66'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      drive();
      #1;
      chk("rst.rel.rinc", 66'(rinc), 66'd0);
      cyc();
      chk("rst.rel1.valid", 66'(out_valid), 66'd0);
      chk("rst.rel1.rinc", 66'(rinc), 66'd1);
      cyc();
      chk_out("rst.w5l0", lane(5, 0), 1'b1, 1'b0);
      cyc();
      chk_out("rst.w5l1", lane(5, 1), 1'b1, 1'b0);

      // INSERT_IDLE=0 variant with a 3-bit counter
      @(negedge clk);
      rst2_n = 1'b1;
      #1;
      chk("ni.rinc0", 66'(rinc2), 66'd0);
      cyc();
      chk("ni.valid0", 66'(valid2), 66'd0);
      chk("ni.cnt0", 66'(cnt2), 66'd0);
      for (int i = 1; i <= 3; i++) begin
         cyc();
         chk("ni.valid", 66'(valid2), 66'd0);
         chk("ni.idle", 66'(idle2), 66'd0);
         chk("ni.cnt", 66'(cnt2), 66'(i));
      end
      rdata2 = word(9);
      rempty2 = 1'b0;
      #1;
      chk("ni.rinc", 66'(rinc2), 66'd1);
      cyc();
      rempty2 = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) cyc();
         chk("ni.block", block2, lane(9, k));
         chk("ni.dvalid", 66'(valid2), 66'd1);
         chk("ni.dcnt", 66'(cnt2), 66'd3);
      end
      for (int i = 4; i <= 9; i++) begin
         cyc();
         chk("ni.evalid", 66'(valid2), 66'd0);
         chk("ni.sat", 66'(cnt2), 66'((i > 7) ? 7 : i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
